// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (diff = a - b, LSB first, one bit per clock) with start/busy/done handshake.
// Optional two's-complement overflow output `ovf` is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] r_nxt;

`ifdef SERIAL_SUB_OVF_EN
  logic             a_sgn;
  logic             b_sgn;
`endif

  // Full-subtractor cell: difference bit and next borrow from the current LSBs.
  always_comb begin
    d_bit  = a_sh[0] ^ b_sh[0] ^ br;
    br_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    r_nxt  = {d_bit, r[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r      <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_sgn  <= 1'b0;
      b_sgn  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            r     <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            a_sgn <= a[WIDTH-1];
            b_sgn <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          r    <= r_nxt;
          br   <= br_nxt;
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          // Last bit: publish the full result so partial sums never reach diff.
          if (cnt == CW'(WIDTH - 1)) begin
            diff   <= r_nxt;
            borrow <= br_nxt;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= (a_sgn != b_sgn) && (d_bit != a_sgn);
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, multi-cycle corner sequences, random sweep.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             br;
    logic             ov;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] d;
    logic             br;
    logic             ov;
  } vec_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   n_accept = 0;
  int   n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("diff", 32'(diff), 32'(e.d));
        check("borrow", 32'(borrow), 32'(e.br));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", 32'(ovf), 32'(e.ov));
`endif
      end
    end
  end

  task automatic push_exp(input logic [WIDTH-1:0] d, input logic br, input logic ov);
    exp_t e;
    e.d = d; e.br = br; e.ov = ov;
    exp_q.push_back(e);
    n_accept++;
  endtask

  // Called right after the accepting edge (+1); returns edges until done and busy cycles seen before it.
  task automatic wait_done(output int lat, output int nbusy);
    lat = 0;
    nbusy = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = k;
        return;
      end
      if (busy === 1'b1) nbusy++;
    end
    check("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic [WIDTH-1:0] ed, input logic ebr, input logic eov);
    int lat, nbusy;
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    push_exp(ed, ebr, eov);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    wait_done(lat, nbusy);
    check("latency", 32'(lat), 32'(WIDTH));
    check("busy_cycles", 32'(nbusy), 32'(WIDTH - 1));
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       output logic [WIDTH-1:0] d, output logic br, output logic ov);
    d  = ia - ib;
    br = (ia < ib);
    ov = (ia[WIDTH-1] != ib[WIDTH-1]) && (d[WIDTH-1] != ia[WIDTH-1]);
  endtask

  initial begin
    vec_t vecs[6];
    int lat, nbusy;
    logic [WIDTH-1:0] ra, rb, md;
    logic mbr, mov;

    vecs[0] = '{a: 8'h5A, b: 8'h23, d: 8'h37, br: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 8'h00, b: 8'h01, d: 8'hFF, br: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 8'h80, b: 8'h01, d: 8'h7F, br: 1'b0, ov: 1'b1};
    vecs[3] = '{a: 8'h7F, b: 8'hFF, d: 8'h80, br: 1'b1, ov: 1'b1};
    vecs[4] = '{a: 8'h01, b: 8'h80, d: 8'h81, br: 1'b1, ov: 1'b1};
    vecs[5] = '{a: 8'hC3, b: 8'hC3, d: 8'h00, br: 1'b0, ov: 1'b0};

    // Reset state
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, vecs[i].ov);

    // Asynchronous reset between edges clears a held nonzero result before the next edge.
    run_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_rst_diff", 32'(diff), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle_busy", 32'(busy), 32'd0);
    check("post_rst_idle_diff", 32'(diff), 32'd0);

    // start held through RUN/DONE with operands changing; re-accept only on the first IDLE edge.
    @(negedge clk);
    a = 8'h10; b = 8'h20; start = 1'b1;
    push_exp(8'hF0, 1'b1, 1'b0);
    @(posedge clk); #1;
    a = 8'hFF; b = 8'h00;
    push_exp(8'hFF, 1'b0, 1'b0);
    wait_done(lat, nbusy);
    check("held_latency", 32'(lat), 32'(WIDTH));
    @(posedge clk); #1;
    check("held_idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("held_reaccept_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(lat, nbusy);
    check("held_second_latency", 32'(lat), 32'(WIDTH));
    @(posedge clk); #1;

    // Reset at cnt = 4: immediate clear, no done for the aborted op.
    @(negedge clk);
    a = 8'h33; b = 8'h11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

    // Reset during the DONE cycle drops done asynchronously.
    @(negedge clk);
    a = 8'h44; b = 8'h04; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, nbusy);
    check("rst_in_done_pre", 32'(done), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_in_done_drop", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Random sweep against the arithmetic model.
    for (int i = 0; i < 200; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      model(ra, rb, md, mbr, mov);
      run_op(ra, rb, md, mbr, mov);
    end

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("done_per_accept", 32'(n_done), 32'(n_accept));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
